// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   dmem_state_t    - responder FSM states (IDLE / WAIT / RESP)
//   DMEM_WORD_BYTES - bytes per 64-bit word
//   DMEM_WORD_SHIFT - log2(DMEM_WORD_BYTES), byte address -> word index
//   dmem_addr_err() - flags a misaligned or out-of-range byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_WORD_BYTES = 8;
  localparam int unsigned DMEM_WORD_SHIFT = 3;

  // Rejects an access that is not doubleword aligned or lies beyond the
  // last word of a depth-word memory.
  function automatic logic dmem_addr_err(input logic [63:0] addr,
                                         input int unsigned depth);
    logic [63:0] limit;
    limit = 64'(depth) * 64'(DMEM_WORD_BYTES);
    return (addr[DMEM_WORD_SHIFT-1:0] != '0) || (addr >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 64-bit storage for the data-memory responder.
// Synchronous write, registered read, synchronous clear of all words and of
// the read register while nreset is low.
// Ports:
//   clk, nreset     - clock, synchronous active-low reset
//   wr_en           - write wdata to mem[idx] on this edge
//   rd_en           - load rdata from mem[idx] on this edge
//   rd_clr          - clear rdata on this edge (rd_en has priority)
//   idx             - word index
//   wdata           - write data
//   rdata           - registered read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (wr_en) begin
        mem[idx] <= wdata;
      end
      if (rd_en) begin
        rdata <= mem[idx];
      end else if (rd_clr) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the LEGv8 MEM-stage load/store interface.
// Accepts one request at a time (valid/ready), performs a 64-bit load or
// store LATENCY cycles later, and returns the result on a valid/ready
// response channel. All outputs are registered.
// Build option: define DMEM_ERR_CHECK_EN to reject misaligned or
// out-of-range accesses (resp_err=1, store suppressed, rdata 0); otherwise
// resp_err is 0 and addresses wrap modulo DEPTH words.
// Ports:
//   clk, nreset                 - clock, synchronous active-low reset
//   req_valid / req_ready       - request handshake
//   req_write, req_addr, req_wdata - store flag, byte address, store data
//   resp_valid / resp_ready     - response handshake
//   resp_rdata, resp_err        - load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t       state;
  logic [CNT_W-1:0]  count;
  logic              cap_write;
  logic [63:0]       cap_addr;
  logic [63:0]       cap_wdata;

  logic              accept;
  logic              enter_resp;
  logic              resp_done;
  logic              acc_write;
  logic [63:0]       acc_addr;
  logic [63:0]       acc_wdata;
  logic              acc_err;
  logic              wr_en;
  logic              rd_en;
  logic              rd_clr;
  logic [IDX_W-1:0]  idx;

  // The access is performed on the edge entering RESP. With LATENCY==1 that
  // is the acceptance edge itself, so the request inputs are used directly
  // instead of the (not yet loaded) capture registers.
  always_comb begin
    accept     = (state == IDLE) && req_valid && req_ready;
    enter_resp = (accept && (LATENCY == 1)) ||
                 ((state == WAIT) && (count == CNT_W'(1)));
    resp_done  = (state == RESP) && resp_ready;
    acc_write  = (state == IDLE) ? req_write : cap_write;
    acc_addr   = (state == IDLE) ? req_addr  : cap_addr;
    acc_wdata  = (state == IDLE) ? req_wdata : cap_wdata;
    idx        = acc_addr[DMEM_WORD_SHIFT +: IDX_W];
  end

`ifdef DMEM_ERR_CHECK_EN
  always_comb begin
    acc_err = dmem_addr_err(acc_addr, DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      resp_err <= 1'b0;
    end else if (enter_resp) begin
      resp_err <= acc_err;
    end else if (resp_done) begin
      resp_err <= 1'b0;
    end
  end
`else
  logic unused_addr_bits;

  always_comb begin
    acc_err          = 1'b0;
    resp_err         = 1'b0;
    unused_addr_bits = ^{acc_addr[DMEM_WORD_SHIFT-1:0],
                         acc_addr[63:DMEM_WORD_SHIFT+IDX_W]};
  end
`endif

  // A store or a rejected access enters RESP with rdata cleared; a completed
  // handshake clears whatever was returned.
  always_comb begin
    wr_en  = enter_resp &&  acc_write && !acc_err;
    rd_en  = enter_resp && !acc_write && !acc_err;
    rd_clr = enter_resp || resp_done;
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .nreset (nreset),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .rd_clr (rd_clr),
    .idx    (idx),
    .wdata  (acc_wdata),
    .rdata  (resp_rdata)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= IDLE;
      count      <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            count     <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined LEGv8 CPU: the slave end of the MEM-stage load/store interface. It accepts one request at a time over a valid/ready handshake and performs a 64-bit doubleword read or write after a fixed access latency. It returns the result over a valid/ready response channel. The block replaces the zero-latency combinational data memory, so the CPU's hazard logic must stall MEM on `req_ready`/`resp_valid`.

## Interface
- `DEPTH`, 64: number of 64-bit words; power of two, ≥2.
- `LATENCY`, 2: cycles from request acceptance to first `resp_valid`; integer ≥1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `nreset` input 1: reset, synchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_write` input 1: 1 = store (STUR), 0 = load (LDUR).
- `req_addr` input 64: byte address.
- `req_wdata` input 64: store data.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: requester consumes the response.
- `resp_rdata` output 64: load data; 0 for stores and errors.
- `resp_err` output 1: access rejected (only with `DMEM_ERR_CHECK_EN`).

## Operation
- FSM states: IDLE, WAIT, RESP.
- Reset values: state IDLE, `req_ready`=0 during reset and 1 on the first cycle after it, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, latency counter 0. Storage is cleared to all zeros.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready`, capture write/addr/wdata and load the counter with LATENCY-1.
  - If LATENCY==1, go to RESP.
  - Otherwise go to WAIT.
- WAIT: `req_ready`=0. The counter decrements each cycle. On the edge where the counter is 1, go to RESP.
- Access happens on the edge that enters RESP, using captured values:
  - Store: write `mem[idx]`=wdata, set `resp_rdata`=0.
  - Load: set `resp_rdata`=`mem[idx]`.
- Word index: idx = addr[2+log2(DEPTH):3]. Bits [2:0] and the bits above the index are ignored unless error checking is enabled.
- RESP: `req_ready`=0 and `resp_valid`=1. `resp_rdata` and `resp_err` are held stable until `resp_ready`. On `resp_valid`&`resp_ready`, go to IDLE and clear `resp_valid`, `resp_rdata` and `resp_err`.
- Only one transaction is outstanding. A request presented outside IDLE is not accepted; the requester must hold it stable.
- A store followed by a load to the same index returns the new data: the store completes before the load can be accepted.
- Reset asserted mid-operation: the FSM returns to IDLE on that edge. A store still in WAIT is never written. A response in RESP is dropped.

## Timing
- Acceptance at edge T → `resp_valid` high from edge T+LATENCY.
- `resp_ready` may be high while `resp_valid` rises; the response then completes on edge T+LATENCY+1.
- `req_ready` is high again the cycle after the response handshake. Minimum spacing between acceptances is LATENCY+1 cycles.
- All outputs are registered or decoded from state. There is no combinational path from any input to any output.

## Configuration
- `DMEM_ERR_CHECK_EN` defined: an access with addr[2:0]≠0 or addr ≥ DEPTH*8 is rejected.
  - The store is suppressed and `resp_rdata`=0.
  - `resp_err`=1 for the whole RESP duration.
  - Latency is unchanged.
- Undefined: `resp_err` is tied to 0, and addresses wrap modulo DEPTH words with low bits ignored.

## Structure
- Shared package `dmem_pkg` holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - `DMEM_WORD_BYTES`=8 and `DMEM_WORD_SHIFT`=3;
  - the error-check helper function (misaligned/out-of-range).
- Sub-module `dmem_array` holds the DEPTH×64 storage: synchronous write, registered read, and a synchronous clear on reset. The top level holds only the FSM, counter and capture registers.

## Test plan
- Reset then a store of addr 0x10, data 0xDEADBEEF_00000001 accepted at edge T (LATENCY=2) → `resp_valid` high at T+2 with `resp_rdata`=0 and `resp_err`=0. `req_ready` stays low from T+1 until the handshake.
- A load of addr 0x10 after that store → `resp_rdata`=0xDEADBEEF_00000001. A load of addr 0x18 → 0.
- `resp_ready` held low for 5 cycles in RESP → `resp_valid`/`resp_rdata` are stable for all 5 cycles, and a pending `req_valid` is not accepted. One cycle after `resp_ready` rises, `req_ready`=1.
- LATENCY=1: a load accepted at T → `resp_valid` at T+1. With `resp_ready` tied high, back-to-back requests are accepted every 2 cycles.
- With `DMEM_ERR_CHECK_EN`:
  - a store to 0x13 → `resp_err`=1, and a later load of 0x10 returns the old value;
  - a load of DEPTH*8 → `resp_err`=1, `resp_rdata`=0.
  
  Without the macro, a load of DEPTH*8+0x10 returns `mem[2]`.
- `nreset`=0 asserted while a store is in WAIT → no write occurs: a subsequent load returns 0, and `resp_valid`=0 on the edge after reset.
